// File: rtl/line_tally.sv
// line_tally: accumulates "rows cleared" events into a 6-bit line count, one unit per clock.
// Define LINES_WRAP_EN to let the count wrap 63->0 instead of saturating at 63.
module line_tally #(
    parameter int MAX_ROWS        = 4,
    parameter int LEVEL_STEP_LOG2 = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       new_game,
    input  logic       game_over,
    input  logic       clear_valid,
    input  logic [2:0] clear_rows,
    output logic       clear_ready,
    output logic [5:0] lines,
    output logic [2:0] level,
    output logic       level_up,
    output logic       saturated
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADD  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    localparam logic [2:0] ROW_CAP = 3'(MAX_ROWS);

`ifdef LINES_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic [1:0] state;
    logic [2:0] pending;
    logic [2:0] rows_clamped;
    logic [5:0] inc_lines;
    logic       inc_boundary;

    // The boundary test requires the count to actually move, so a saturated
    // count sitting at 63 never re-fires level_up.
    always_comb begin
        rows_clamped = (clear_rows > ROW_CAP) ? ROW_CAP : clear_rows;
        if (!WRAP && lines == 6'd63)
            inc_lines = lines;
        else
            inc_lines = lines + 6'd1;
        inc_boundary = (inc_lines != lines) &&
                       (inc_lines[LEVEL_STEP_LOG2-1:0] == '0);
    end

    assign level = 3'(lines >> LEVEL_STEP_LOG2);

`ifdef LINES_WRAP_EN
    assign saturated = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            pending     <= '0;
            lines       <= '0;
            clear_ready <= 1'b0;
            level_up    <= 1'b0;
`ifndef LINES_WRAP_EN
            saturated   <= 1'b0;
`endif
        end else if (new_game) begin
            state       <= IDLE;
            pending     <= '0;
            lines       <= '0;
            clear_ready <= 1'b1;
            level_up    <= 1'b0;
`ifndef LINES_WRAP_EN
            saturated   <= 1'b0;
`endif
        end else if (game_over) begin
            state       <= HOLD;
            pending     <= '0;
            clear_ready <= 1'b0;
            level_up    <= 1'b0;
        end else begin
            level_up <= 1'b0;
            case (state)
                IDLE: begin
                    clear_ready <= 1'b1;
                    if (clear_valid && clear_ready) begin
                        pending <= rows_clamped;
                        if (rows_clamped != 3'd0) begin
                            state       <= ADD;
                            clear_ready <= 1'b0;
                        end
                    end
                end
                // Pending drains at one per clock even when saturated, so the
                // handshake timing never depends on the count value.
                ADD: begin
                    lines    <= inc_lines;
                    level_up <= inc_boundary;
                    pending  <= pending - 3'd1;
`ifndef LINES_WRAP_EN
                    saturated <= (inc_lines == 6'd63);
`endif
                    if (pending == 3'd1) begin
                        state       <= IDLE;
                        clear_ready <= 1'b1;
                    end
                end
                default: begin
                    state       <= HOLD;
                    clear_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_tally.sv
// tb_line_tally: directed-vector self-checking bench for line_tally.
// Expected values are hand-computed per step; LINES_WRAP_EN selects the wrap expectations.
module tb_line_tally;

    logic       clk = 1'b0;
    logic       reset;
    logic       new_game;
    logic       game_over;
    logic       clear_valid;
    logic [2:0] clear_rows;
    logic       clear_ready;
    logic [5:0] lines;
    logic [2:0] level;
    logic       level_up;
    logic       saturated;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    line_tally #(.MAX_ROWS(4), .LEVEL_STEP_LOG2(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .new_game   (new_game),
        .game_over  (game_over),
        .clear_valid(clear_valid),
        .clear_rows (clear_rows),
        .clear_ready(clear_ready),
        .lines      (lines),
        .level      (level),
        .level_up   (level_up),
        .saturated  (saturated)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic ng, input logic go, input logic v, input logic [2:0] r);
        new_game    = ng;
        game_over   = go;
        clear_valid = v;
        clear_rows  = r;
    endtask

    // Offer one event for a single edge, then wait (bounded) for ready to return.
    task automatic runEvent(input logic [2:0] r);
        int n;
        applyStimulus(1'b0, 1'b0, 1'b1, r);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'd0);
        n = 0;
        while (!clear_ready && n < 20) begin
            tick();
            n++;
        end
        checkOutput("event_drain_ready", 32'(clear_ready), 32'd1);
    endtask

    initial begin
        logic [5:0] exp_lines;
        logic       exp_lu;
        logic       exp_sat;

        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 3'd0);
        tick();
        tick();
        tick();
        checkOutput("rst_lines", 32'(lines), 32'd0);
        checkOutput("rst_ready", 32'(clear_ready), 32'd0);
        checkOutput("rst_level_up", 32'(level_up), 32'd0);
        checkOutput("rst_saturated", 32'(saturated), 32'd0);
        reset = 1'b1;
        checkOutput("rel_ready_before_edge", 32'(clear_ready), 32'd0);
        tick();
        checkOutput("rel_ready_after_edge", 32'(clear_ready), 32'd1);

        // rows=5 clamps to 4, then +1 brings lines to 5
        runEvent(3'd5);
        checkOutput("clamp5_lines", 32'(lines), 32'd4);
        runEvent(3'd1);
        checkOutput("setup_lines5", 32'(lines), 32'd5);

        // 4 rows from 5: 6,7,8,9 with level_up after reaching 8
        applyStimulus(1'b0, 1'b0, 1'b1, 3'd4);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'd0);
        checkOutput("add4_accept_ready", 32'(clear_ready), 32'd0);
        checkOutput("add4_accept_lines", 32'(lines), 32'd5);
        for (int i = 1; i <= 4; i++) begin
            tick();
            checkOutput("add4_lines", 32'(lines), 32'(5 + i));
            checkOutput("add4_level_up", 32'(level_up), 32'((5 + i) == 8));
            checkOutput("add4_ready", 32'(clear_ready), 32'(i == 4));
        end
        checkOutput("level_at_9", 32'(level), 32'd1);

        // Back-to-back 3 then 2 with valid held high
        applyStimulus(1'b0, 1'b0, 1'b1, 3'd3);
        tick();
        clear_rows = 3'd2;
        tick();
        tick();
        checkOutput("b2b_mid_ready", 32'(clear_ready), 32'd0);
        tick();
        checkOutput("b2b_first_done_lines", 32'(lines), 32'd12);
        checkOutput("b2b_first_done_ready", 32'(clear_ready), 32'd1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'd0);
        checkOutput("b2b_second_accept_ready", 32'(clear_ready), 32'd0);
        checkOutput("b2b_second_accept_lines", 32'(lines), 32'd12);
        tick();
        checkOutput("b2b_lines13", 32'(lines), 32'd13);
        tick();
        checkOutput("b2b_final_lines", 32'(lines), 32'd14);
        checkOutput("b2b_final_ready", 32'(clear_ready), 32'd1);

        // rows=7 treated as 4; crosses 16
        runEvent(3'd7);
        checkOutput("clamp7_lines", 32'(lines), 32'd18);
        checkOutput("level_at_18", 32'(level), 32'd2);

        // rows=0 consumed without change
        applyStimulus(1'b0, 1'b0, 1'b1, 3'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'd0);
        checkOutput("zero_ready", 32'(clear_ready), 32'd1);
        tick();
        checkOutput("zero_lines", 32'(lines), 32'd18);

        // Climb to 62 (11 events of 4)
        for (int e = 0; e < 11; e++) runEvent(3'd4);
        checkOutput("setup_lines62", 32'(lines), 32'd62);
        checkOutput("level_at_62", 32'(level), 32'd7);

        applyStimulus(1'b0, 1'b0, 1'b1, 3'd4);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'd0);
        for (int i = 1; i <= 4; i++) begin
            tick();
`ifdef LINES_WRAP_EN
            exp_lines = 6'(62 + i);
            exp_lu    = (i == 2);
            exp_sat   = 1'b0;
`else
            exp_lines = 6'd63;
            exp_lu    = 1'b0;
            exp_sat   = 1'b1;
`endif
            checkOutput("top_lines", 32'(lines), 32'(exp_lines));
            checkOutput("top_level_up", 32'(level_up), 32'(exp_lu));
            checkOutput("top_saturated", 32'(saturated), 32'(exp_sat));
            checkOutput("top_ready", 32'(clear_ready), 32'(i == 4));
        end

        // new_game clears; an event offered alongside is ignored
        applyStimulus(1'b1, 1'b0, 1'b1, 3'd3);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'd0);
        checkOutput("ng_lines", 32'(lines), 32'd0);
        checkOutput("ng_ready", 32'(clear_ready), 32'd1);
        checkOutput("ng_level_up", 32'(level_up), 32'd0);
        checkOutput("ng_saturated", 32'(saturated), 32'd0);
        tick();
        checkOutput("ng_event_dropped", 32'(lines), 32'd0);

        // game_over mid-ADD after 2 of 4 rows
        applyStimulus(1'b0, 1'b0, 1'b1, 3'd4);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'd0);
        tick();
        tick();
        checkOutput("go_before_lines", 32'(lines), 32'd2);
        game_over = 1'b1;
        tick();
        checkOutput("go_frozen_lines", 32'(lines), 32'd2);
        checkOutput("go_ready", 32'(clear_ready), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 3'd3);
        tick();
        tick();
        tick();
        checkOutput("hold_lines", 32'(lines), 32'd2);
        checkOutput("hold_ready", 32'(clear_ready), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 3'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'd0);
        checkOutput("hold_ng_lines", 32'(lines), 32'd0);
        checkOutput("hold_ng_ready", 32'(clear_ready), 32'd1);
        runEvent(3'd2);
        checkOutput("after_hold_lines", 32'(lines), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
